status_display_scanner: RTL and testbench
=========================================

# status_display_scanner

Multiplexed multi-digit seven-segment driver for the pill-bottling controller. Digit 0 shows the machine-status glyph and digits 1..DIGITS-1 show a BCD counter value, such as the bottle count, from the counting logic. Adds time-multiplexed scanning, frame-synchronous input snapshotting, leading-zero blanking and optional blinking for error and pause indication. Sits between the control FSM/counters and the board display pins.

## Interface
- DIGITS, 4, number of physical digits (status + DIGITS-1 value digits); legal ≥ 2
- SCAN_DIV, 50000, clock cycles each digit stays selected; legal ≥ 2
- BLINK_DIV, 32, full scan frames per blink half-period; legal ≥ 1
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- in_state  input  2  00 zero, 01 operation, 10 report, 11 report
- in_suspend, in_finish, in_next_bottle, in_setting, in_warning_enable  input  1 each  status flags
- in_bcd  input  4*(DIGITS-1)  BCD value; nibble k drives digit k+1; nibble 0 is the least significant
- out_seg  output  7  segments a..g, bit 6 = a, bit 0 = g, active-high
- out_dig_sel  output  DIGITS  one-hot digit enable, active-high, bit i = digit i

## Operation
- scan_cnt counts 0..SCAN_DIV-1. On terminal count, digit index idx advances and wraps from DIGITS-1 to 0.
- Frame end is the terminal count with idx = DIGITS-1. At frame end, all status inputs and in_bcd are captured into a snapshot register. The displayed content never changes mid-frame.
- Status glyph is computed from the snapshot, in priority order:
  - warning → E 1001111
  - setting → S 1011011
  - state 00 → 0 1111110
  - state 01:
    - finish=1, next=0 → underline 0001000
    - finish=0, next=1 → suspend ? P 1100111 : three-line 1001001
    - otherwise → suspend ? P : upline 1000000
  - state 10/11 → underline
- Value digit k+1 shows nibble k decoded 0–9. A nibble > 9 shows dash 0000001.
- Leading-zero blanking: a value digit is blank (0000000) if its nibble and all more-significant nibbles are 0. Digit 1 is never blanked.
- Output register: out_dig_sel = onehot(idx), out_seg = glyph for idx after blink masking. There is one clock of latency from an idx change to the outputs.

## Timing
- Reset values:
  - out_seg = 0000000, out_dig_sel = 0
  - scan_cnt = 0, idx = 0, blink_cnt = 0, blink_phase = 0
  - snapshot = state 00, all flags 0, bcd all 0
- First clock after reset release: out_dig_sel = 1, out_seg = 1111110.
- Input changes appear on the display at the first frame end after the change, plus 1 cycle.
- Reset asserted mid-frame immediately forces all reset values, asynchronously.
- Simultaneous flags resolve by the priority list above. The finish+next combination is treated as the "otherwise" case.

## Configuration
- DISPLAY_BLINK_EN defined:
  - blink_cnt counts frame ends 0..BLINK_DIV-1. At terminal count, blink_phase toggles.
  - When snapshot warning=1 and blink_phase=1, every digit outputs 0000000.
  - When the status glyph is P and blink_phase=1, digit 0 outputs 0000000; value digits are unaffected.
- Not defined: blink_cnt and blink_phase are absent, and glyphs are always shown steadily.

## Structure
- Shared package display_pkg holds:
  - glyph constants c_E, c_S, c_P, c_0, g_u, g_b_report, g_t, g_dash, g_blank
  - state encodings s_zero, s_operation, s_report
- Sub-module seg_bcd_decoder: combinational 4-bit BCD to 7-segment, dash for values > 9. Instantiated once on the snapshot nibble selected by idx.

## Test plan
Parameters for all scenarios: DIGITS=4, SCAN_DIV=4, BLINK_DIV=2.
- Reset, then state 00, bcd 0x000 → out_dig_sel cycles 0001,0010,0100,1000 every 4 clocks; seg 1111110, 1111110 (digit 1, not blanked), 0000000, 0000000.
- bcd 0x105, state 01, all flags 0 → after the next frame end: digit 0 = 1000000, digit 1 = 1011011 (5), digit 2 = 1111110 (0), digit 3 = 0110000 (1).
- Change in_bcd mid-frame at idx=1 → remaining digits of the current frame still show the old value; the new value appears from the next frame.
- in_warning_enable=1 together with in_setting=1, with DISPLAY_BLINK_EN defined → digit 0 = 1001111. All digits blank during alternate 2-frame periods (32 clocks on, 32 off).
- state 01, suspend=1, next=1, with DISPLAY_BLINK_EN defined → digit 0 alternates 1100111 / 0000000 every 2 frames; value digits steady. Without the macro, 1100111 is shown steadily.
- Assert rst at idx=2 mid-scan → outputs go to 0 immediately. After release, the sequence restarts at digit 0 with glyph 1111110.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the status display scanner.
// Holds the seven-segment glyph constants (bit 6 = segment a, bit 0 = g,
// active-high), the machine-state encodings, the snapshot struct and the
// status-glyph priority function used by the top level.
package display_pkg;

  localparam logic [6:0] c_E        = 7'b1001111;  // warning
  localparam logic [6:0] c_S        = 7'b1011011;  // setting
  localparam logic [6:0] c_P        = 7'b1100111;  // paused
  localparam logic [6:0] c_0        = 7'b1111110;  // zero state
  localparam logic [6:0] g_u        = 7'b1000000;  // upline: running
  localparam logic [6:0] g_b_report = 7'b0001000;  // underline: finished/report
  localparam logic [6:0] g_t        = 7'b1001001;  // three-line: next bottle
  localparam logic [6:0] g_dash     = 7'b0000001;  // non-BCD nibble
  localparam logic [6:0] g_blank    = 7'b0000000;

  typedef enum logic [1:0] {
    s_zero      = 2'b00,
    s_operation = 2'b01,
    s_report    = 2'b10
  } state_e;

  // Status inputs captured once per frame.
  typedef struct packed {
    logic [1:0] state;
    logic       suspend;
    logic       finish;
    logic       next_bottle;
    logic       setting;
    logic       warning;
  } status_t;

  // True when the status digit shows the pause glyph (used for blinking).
  function automatic logic status_is_pause(status_t s);
    logic p;
    p = 1'b0;
    if (!s.warning && !s.setting && (s.state == s_operation) &&
        !(s.finish && !s.next_bottle))
      p = s.suspend;
    return p;
  endfunction

  // Priority: warning, setting, then machine state. finish+next together
  // falls through to the plain running case.
  function automatic logic [6:0] status_glyph(status_t s);
    logic [6:0] g;
    g = g_b_report;
    if (s.warning)       g = c_E;
    else if (s.setting)  g = c_S;
    else begin
      case (s.state)
        s_zero:      g = c_0;
        s_operation: begin
          if (s.finish && !s.next_bottle)      g = g_b_report;
          else if (!s.finish && s.next_bottle) g = s.suspend ? c_P : g_t;
          else                                 g = s.suspend ? c_P : g_u;
        end
        default:     g = g_b_report;  // 10 and 11 both mean report
      endcase
    end
    return g;
  endfunction

endpackage

// File: rtl/seg_bcd_decoder.sv
// Combinational BCD to seven-segment decoder.
// Ports: bcd_i - 4-bit digit value; seg_o - segments a..g (bit 6 = a),
// active-high. Values above 9 produce a dash.
module seg_bcd_decoder
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = g_dash;
    case (bcd_i)
      4'd0:    seg_o = c_0;
      4'd1:    seg_o = 7'b0110000;
      4'd2:    seg_o = 7'b1101101;
      4'd3:    seg_o = 7'b1111001;
      4'd4:    seg_o = 7'b0110011;
      4'd5:    seg_o = 7'b1011011;
      4'd6:    seg_o = 7'b1011111;
      4'd7:    seg_o = 7'b1110000;
      4'd8:    seg_o = 7'b1111111;
      4'd9:    seg_o = 7'b1111011;
      default: seg_o = g_dash;
    endcase
  end

endmodule

// File: rtl/status_display_scanner.sv
// Multiplexed seven-segment driver: digit 0 shows a machine-status glyph,
// digits 1..DIGITS-1 show a BCD value with leading-zero blanking.
// Inputs are snapshotted once per scan frame so a frame never mixes values.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   in_state, in_*  - machine state and status flags
//   in_bcd          - BCD value, nibble k shown on digit k+1 (nibble 0 = LSD)
//   out_seg         - segments a..g, bit 6 = a, active-high, registered
//   out_dig_sel     - one-hot digit enable, registered
// Optional feature: define DISPLAY_BLINK_EN to blink the whole display on
// warning and the status digit on pause, toggling every BLINK_DIV frames.
module status_display_scanner
  import display_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                in_state,
  input  logic                      in_suspend,
  input  logic                      in_finish,
  input  logic                      in_next_bottle,
  input  logic                      in_setting,
  input  logic                      in_warning_enable,
  input  logic [4*(DIGITS-1)-1:0]   in_bcd,
  output logic [6:0]                out_seg,
  output logic [DIGITS-1:0]         out_dig_sel
);

  localparam int BCD_W  = 4 * (DIGITS - 1);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = $clog2(DIGITS);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  if (DIGITS < 2 || SCAN_DIV < 2 || BLINK_DIV < 1) begin : g_bad_params
    $error("status_display_scanner: illegal parameter value");
  end

  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  status_t           snap_q, snap_d;
  logic [BCD_W-1:0]  snap_bcd_q, snap_bcd_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] dig_sel_q, dig_sel_d;

  logic       scan_tc, frame_end;
  logic [3:0] sel_nib;
  logic       sel_blank, upper_nz;
  logic [6:0] dec_seg;
  logic       blink_mask;

  // Scan timing and frame snapshot.
  always_comb begin
    scan_tc    = (scan_cnt_q == SCAN_LAST);
    frame_end  = scan_tc && (idx_q == IDX_LAST);
    scan_cnt_d = scan_tc ? '0 : scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    snap_d     = snap_q;
    snap_bcd_d = snap_bcd_q;
    if (frame_end) begin
      snap_d.state       = in_state;
      snap_d.suspend     = in_suspend;
      snap_d.finish      = in_finish;
      snap_d.next_bottle = in_next_bottle;
      snap_d.setting     = in_setting;
      snap_d.warning     = in_warning_enable;
      snap_bcd_d         = in_bcd;
    end
  end

  // Pick the nibble for the current digit. Walking from the most-significant
  // nibble down, upper_nz tells whether anything at or above nibble k is
  // non-zero; digit 1 always shows so a zero value reads "0".
  always_comb begin
    sel_nib   = 4'd0;
    sel_blank = 1'b0;
    upper_nz  = 1'b0;
    for (int k = DIGITS - 2; k >= 0; k--) begin
      upper_nz = upper_nz | (snap_bcd_q[4*k +: 4] != 4'd0);
      if (idx_q == IDX_W'(k + 1)) begin
        sel_nib   = snap_bcd_q[4*k +: 4];
        sel_blank = !upper_nz && (k != 0);
      end
    end
  end

  seg_bcd_decoder u_dec (
    .bcd_i (sel_nib),
    .seg_o (dec_seg)
  );

`ifdef DISPLAY_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    // Warning blanks everything; pause blanks only the status digit.
    blink_mask = blink_phase_q &&
                 (snap_q.warning || ((idx_q == '0) && status_is_pause(snap_q)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`else
  always_comb blink_mask = 1'b0;
`endif

  // Output register: content for the digit currently indexed.
  always_comb begin
    if (idx_q == '0)    seg_d = status_glyph(snap_q);
    else if (sel_blank) seg_d = g_blank;
    else                seg_d = dec_seg;
    if (blink_mask) seg_d = g_blank;
    for (int i = 0; i < DIGITS; i++) dig_sel_d[i] = (idx_q == IDX_W'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      snap_q     <= '{state: s_zero, default: 1'b0};
      snap_bcd_q <= '0;
      seg_q      <= g_blank;
      dig_sel_q  <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      snap_bcd_q <= snap_bcd_d;
      seg_q      <= seg_d;
      dig_sel_q  <= dig_sel_d;
    end
  end

  assign out_seg     = seg_q;
  assign out_dig_sel = dig_sel_q;

endmodule

// File: tb/tb_status_display_scanner.sv
// Bench for status_display_scanner with DIGITS=4, SCAN_DIV=4, BLINK_DIV=2.
// A cycle-count based model predicts every output; literal checks pin the
// documented scenarios.
module tb_status_display_scanner;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;
  localparam int BCD_W     = 4 * (DIGITS - 1);
  localparam int FRAME     = SCAN_DIV * DIGITS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        in_state = 2'b00;
  logic              in_suspend = 0, in_finish = 0, in_next_bottle = 0;
  logic              in_setting = 0, in_warning_enable = 0;
  logic [BCD_W-1:0]  in_bcd = '0;
  logic [6:0]        out_seg;
  logic [DIGITS-1:0] out_dig_sel;

  status_display_scanner #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst(rst),
    .in_state(in_state), .in_suspend(in_suspend), .in_finish(in_finish),
    .in_next_bottle(in_next_bottle), .in_setting(in_setting),
    .in_warning_enable(in_warning_enable), .in_bcd(in_bcd),
    .out_seg(out_seg), .out_dig_sel(out_dig_sel)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act[6:0], exp[6:0], $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] seg_lut [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011};

  function automatic logic [6:0] model_seg(input int digit, input logic [1:0] st,
      input logic sus, input logic fin, input logic nxt, input logic set,
      input logic warn, input logic [BCD_W-1:0] bcd, input logic phase);
    logic [6:0] g;
    logic       is_p;
    int         rest, nib;
    is_p = 1'b0;
    g    = 7'b0000000;
    if (digit == 0) begin
      if (warn)              g = 7'b1001111;
      else if (set)          g = 7'b1011011;
      else if (st == 2'b00)  g = 7'b1111110;
      else if (st == 2'b01) begin
        if (fin && !nxt)     g = 7'b0001000;
        else begin
          is_p = sus;
          if (sus)           g = 7'b1100111;
          else if (!fin && nxt) g = 7'b1001001;
          else               g = 7'b1000000;
        end
      end else               g = 7'b0001000;
    end else begin
      rest = int'(bcd >> (4 * (digit - 1)));
      nib  = rest % 16;
      if (rest == 0 && digit != 1) g = 7'b0000000;
      else if (nib > 9)            g = 7'b0000001;
      else                         g = seg_lut[nib];
    end
`ifdef DISPLAY_BLINK_EN
    if (phase && (warn || (digit == 0 && is_p))) g = 7'b0000000;
`else
    if (phase && 1'b0) g = 7'b0000000;
`endif
    return g;
  endfunction

  int                m_edges, m_frames;
  logic [1:0]        m_state;
  logic              m_sus, m_fin, m_nxt, m_set, m_warn;
  logic [BCD_W-1:0]  m_bcd;
  logic [6:0]        exp_seg;
  logic [DIGITS-1:0] exp_sel;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edges <= 0; m_frames <= 0;
      m_state <= 2'b00; m_sus <= 0; m_fin <= 0; m_nxt <= 0; m_set <= 0; m_warn <= 0;
      m_bcd <= '0; exp_seg <= '0; exp_sel <= '0;
    end else begin
      exp_sel <= DIGITS'(1) << ((m_edges / SCAN_DIV) % DIGITS);
      exp_seg <= model_seg((m_edges / SCAN_DIV) % DIGITS, m_state, m_sus, m_fin, m_nxt,
                           m_set, m_warn, m_bcd, ((m_frames / BLINK_DIV) % 2) == 1);
      if ((m_edges + 1) % FRAME == 0) begin
        m_state <= in_state; m_sus <= in_suspend; m_fin <= in_finish;
        m_nxt <= in_next_bottle; m_set <= in_setting; m_warn <= in_warning_enable;
        m_bcd <= in_bcd;
        m_frames <= m_frames + 1;
      end
      m_edges <= m_edges + 1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_seg", 32'(out_seg), 32'(exp_seg));
      check("model_sel", 32'(out_dig_sel), 32'(exp_sel));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_digit(input int d);
    bit found;
    found = 0;
    for (int i = 0; i < 4 * FRAME && !found; i++) begin
      @(negedge clk);
      if (out_dig_sel == (DIGITS'(1) << d)) found = 1;
    end
    if (!found) check("wait_digit_timeout", 32'(0), 32'(1));
  endtask

  task automatic next_frame();
    wait_digit(3);
    wait_digit(0);
  endtask

  task automatic set_status(input logic [1:0] st, input logic sus, input logic fin,
      input logic nxt, input logic set, input logic warn);
    in_state = st; in_suspend = sus; in_finish = fin;
    in_next_bottle = nxt; in_setting = set; in_warning_enable = warn;
  endtask

  task automatic random_inputs();
    set_status(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    for (int k = 0; k < DIGITS - 1; k++)
      in_bcd[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;

    // Reset release: first frame shows zero state, bcd 0.
    @(negedge clk);
    check("first_sel", 32'(out_dig_sel), 32'b0001);
    check("first_seg", 32'(out_seg), 32'b1111110);
    wait_digit(1); check("zero_d1", 32'(out_seg), 32'b1111110);
    wait_digit(2); check("zero_d2", 32'(out_seg), 32'b0000000);
    wait_digit(3); check("zero_d3", 32'(out_seg), 32'b0000000);

    // Running state with 105.
    set_status(2'b01, 0, 0, 0, 0, 0);
    in_bcd = 12'h105;
    next_frame();  check("r105_d0", 32'(out_seg), 32'b1000000);
    wait_digit(1); check("r105_d1", 32'(out_seg), 32'b1011011);
    wait_digit(2); check("r105_d2", 32'(out_seg), 32'b1111110);
    wait_digit(3); check("r105_d3", 32'(out_seg), 32'b0110000);

    // Mid-frame change: current frame keeps 105.
    wait_digit(1);
    in_bcd = 12'h987;
    wait_digit(2); check("mid_old_d2", 32'(out_seg), 32'b1111110);
    wait_digit(3); check("mid_old_d3", 32'(out_seg), 32'b0110000);
    wait_digit(0); check("mid_new_d0", 32'(out_seg), 32'b1000000);
    wait_digit(1); check("mid_new_d1", 32'(out_seg), 32'b1110000);
    wait_digit(2); check("mid_new_d2", 32'(out_seg), 32'b1111111);
    wait_digit(3); check("mid_new_d3", 32'(out_seg), 32'b1111011);

    // Non-BCD nibble and blanking above it.
    in_bcd = 12'h0A0;
    next_frame();
    wait_digit(1); check("dash_d1", 32'(out_seg), 32'b1111110);
    wait_digit(2); check("dash_d2", 32'(out_seg), 32'b0000001);
    wait_digit(3); check("dash_d3", 32'(out_seg), 32'b0000000);

    // Warning beats setting.
    set_status(2'b01, 0, 0, 0, 1, 1);
    next_frame();
`ifndef DISPLAY_BLINK_EN
    check("warn_d0", 32'(out_seg), 32'b1001111);
`endif
    repeat (5 * FRAME) @(negedge clk);

    // Paused with next bottle; finish+next counts as running.
    set_status(2'b01, 1, 0, 1, 0, 0);
    next_frame();
`ifndef DISPLAY_BLINK_EN
    for (int f = 0; f < 3; f++) begin
      check("pause_d0", 32'(out_seg), 32'b1100111);
      next_frame();
    end
`endif
    repeat (5 * FRAME) @(negedge clk);
    set_status(2'b01, 0, 1, 1, 0, 0);
    next_frame();
`ifndef DISPLAY_BLINK_EN
    check("fin_next_d0", 32'(out_seg), 32'b1000000);
`endif
    set_status(2'b11, 0, 0, 0, 0, 0);
    next_frame();
`ifndef DISPLAY_BLINK_EN
    check("report11_d0", 32'(out_seg), 32'b0001000);
`endif

    // Randomised traffic, checked by the model every cycle.
    for (int n = 0; n < 150; n++) begin
      random_inputs();
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    // Asynchronous reset in the middle of digit 2.
    wait_digit(2);
    #3 rst = 1'b1;
    #1;
    check("async_rst_seg", 32'(out_seg), 32'b0);
    check("async_rst_sel", 32'(out_dig_sel), 32'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rerun_sel", 32'(out_dig_sel), 32'b0001);
    check("rerun_seg", 32'(out_seg), 32'b1111110);
    repeat (3 * FRAME) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
